pcpi_result_serializer: RTL and testbench
=========================================

PCPI_RESULT_SERIALIZER -- requirements
Module: pcpi_result_serializer

Interface
REQ-001 Parameter DEPTH, default 2: number of 32-bit result entries buffered; power of two, 2..4.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 pcpi_ready  input  1  coprocessor completion strobe, one cycle wide.
REQ-005 pcpi_wr  input  1  coprocessor result valid for writeback, qualified by pcpi_ready.
REQ-006 pcpi_rd  input  32  coprocessor result word, valid when pcpi_ready&pcpi_wr.
REQ-007 host_ack  input  1  host acknowledge of the presented nibble (four-phase).
REQ-008 nib_out  output  4  nibble presented to host.
REQ-009 nib_valid  output  1  nib_out valid; registered.
REQ-010 fifo_count  output  $clog2(DEPTH)+1  number of buffered results, including the one being sent.
REQ-011 overflow  output  1  sticky flag: a result was dropped because the buffer was full.

Function
REQ-012 The block SHALL push pcpi_rd into the FIFO on every edge where pcpi_ready=1 and pcpi_wr=1; pcpi_ready with pcpi_wr=0 SHALL be ignored.
REQ-013 Each result SHALL be sent as 8 nibbles, least-significant first (bits 3:0, then 7:4, ... 31:28).
REQ-014 FSM states SHALL be IDLE, PRESENT, RELEASE; nib_valid=1 only in PRESENT.
REQ-015 IDLE: if fifo_count>0, go to PRESENT next edge with nibble index 0; else stay.
REQ-016 PRESENT: hold nib_out stable; on host_ack=1 go to RELEASE.
REQ-017 RELEASE: wait for host_ack=0; then if index<7 increment index and go to PRESENT, else pop head entry, clear index, go to IDLE.
REQ-018 nib_out SHALL equal the indexed nibble of the head entry in PRESENT and 4'h0 otherwise.
REQ-019 Latency: push at edge E0 with empty FIFO and IDLE SHALL give nib_valid=1 after edge E1.
REQ-020 Full with no pop on same edge: the push SHALL be dropped, FIFO contents unchanged, overflow set to 1.
REQ-021 Full with pop on same edge: the push SHALL be accepted, fifo_count unchanged.
REQ-022 Push and pop on the same edge with a non-full FIFO SHALL leave fifo_count unchanged.
REQ-023 overflow SHALL clear only on reset.
REQ-024 host_ack already high on entering PRESENT SHALL be honoured (transition to RELEASE next edge); no nibble is skipped.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 On rst_n=0 at an edge: state IDLE, index 0, pointers 0, fifo_count 0, nib_valid 0, nib_out 4'h0, overflow 0.
REQ-027 Reset mid-transfer SHALL discard all buffered and partially sent results; a push coincident with reset SHALL be dropped.
REQ-028 FIFO data storage SHALL not require reset.

Structure
REQ-029 FSM state encoding and NIBBLES_PER_WORD=8 SHALL live in the shared project package used by the instruction deserializer.
REQ-030 The FIFO SHALL be a separate sub-module, pcpi_result_fifo (push, pop, data, count, full, empty); the FSM and nibble mux SHALL stay in the top.

Verification
REQ-031 Push 32'h89ABCDEF, host acks each nibble with one-cycle-high/low -> nibbles F,E,D,C,B,A,9,8 in order; fifo_count 1->0 after last release.
REQ-032 Push at E0 into empty idle block -> nib_valid=1 after E1; host_ack held low 20 cycles -> nib_out=F, nib_valid held stable.
REQ-033 DEPTH=2, push 32'h11111111, 32'h22222222, 32'h33333333 with no acks -> third dropped, overflow=1, fifo_count=2; both surviving words later sent intact.
REQ-034 Full FIFO, push on the same edge as final pop of 32'h11111111 -> push accepted, fifo_count stays 2, overflow stays 0.
REQ-035 pcpi_ready=1, pcpi_wr=0 with pcpi_rd=32'hDEADBEEF -> no push, fifo_count 0, nib_valid 0.
REQ-036 Reset asserted after 3 nibbles of 32'h12345678 -> next edge nib_valid 0, fifo_count 0; a new push 32'h0000000A afterwards sends A first.

Source files
------------

// File: rtl/pcpi_result_serializer_pkg.sv
// Shared PCPI serializer/deserializer definitions.
// Holds the nibble-transfer FSM encoding, the words-to-nibbles geometry and a
// helper that picks one nibble out of a 32-bit word.
package pcpi_result_serializer_pkg;

  localparam int NIBBLES_PER_WORD = 8;
  localparam int NIB_IDX_W        = $clog2(NIBBLES_PER_WORD);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_RELEASE = 2'd2
  } ser_state_e;

  // Nibble idx of w, idx 0 = bits 3:0.
  function automatic logic [3:0] word_nibble(input logic [31:0]          w,
                                             input logic [NIB_IDX_W-1:0] idx);
    return w[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/pcpi_result_fifo.sv
// Result FIFO for the PCPI serializer.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (pointers/count only)
//   push, wdata     write request and word
//   pop             drop head entry (ignored when empty)
//   rdata           head entry
//   count           occupancy, 0..DEPTH
//   full, empty     occupancy flags
// A push while full is accepted only if a pop frees the slot on the same edge.
module pcpi_result_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][31:0] mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; gating with rst_n keeps a reset-cycle push inert.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pcpi_result_serializer.sv
// Buffers PCPI coprocessor results and sends each one to the host as eight
// nibbles, LS nibble first, over a four-phase nib_valid/host_ack handshake.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pcpi_ready, pcpi_wr   result strobe / writeback-valid (pushed when both 1)
//   pcpi_rd               result word
//   host_ack              host acknowledge of the presented nibble
//   nib_out, nib_valid    nibble to host and its valid (valid only in PRESENT)
//   fifo_count            buffered results, including the one being sent
//   overflow              sticky: a result was dropped on a full buffer
module pcpi_result_serializer
  import pcpi_result_serializer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pcpi_ready,
  input  logic                   pcpi_wr,
  input  logic [31:0]            pcpi_rd,
  input  logic                   host_ack,
  output logic [3:0]             nib_out,
  output logic                   nib_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  ser_state_e           state, state_d;
  logic [NIB_IDX_W-1:0] idx, idx_d;
  logic                 push, pop, full, empty;
  logic [31:0]          head;

  assign push = pcpi_ready && pcpi_wr;

  pcpi_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (pcpi_rd),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state;
    idx_d   = idx;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_PRESENT;
          idx_d   = '0;
        end
      end
      // An ack already high on entry is taken on the next edge, so the
      // presented nibble is still seen for one cycle and none is skipped.
      S_PRESENT: begin
        if (host_ack) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!host_ack) begin
          if (idx != NIB_IDX_W'(NIBBLES_PER_WORD - 1)) begin
            idx_d   = idx + 1'b1;
            state_d = S_PRESENT;
          end else begin
            // Head stays counted until its last nibble is released.
            pop     = 1'b1;
            idx_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      nib_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      nib_valid <= (state_d == S_PRESENT);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Head and idx are both frozen while PRESENT, so nib_out holds stable.
  assign nib_out = nib_valid ? word_nibble(head, idx) : 4'h0;

endmodule

// File: tb/tb_pcpi_result_serializer.sv
module tb_pcpi_result_serializer;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          pcpi_ready = 1'b0, pcpi_wr = 1'b0, host_ack = 1'b0;
  logic [31:0]   pcpi_rd = '0;
  logic [3:0]    nib_out;
  logic          nib_valid, overflow;
  logic [CW-1:0] fifo_count;

  pcpi_result_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr),
    .pcpi_rd(pcpi_rd), .host_ack(host_ack), .nib_out(nib_out),
    .nib_valid(nib_valid), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Transaction-level model: a queue of words plus the host handshake
  // position (0 idle, 1 nibble shown, 2 waiting for ack release).
  logic [31:0] q[$];
  int          m_phase = 0, m_idx = 0;
  bit          m_ovf = 0;

  always @(posedge clk) begin
    bit popd;
    popd = 0;
    if (!rst_n) begin
      q.delete();
      m_phase = 0; m_idx = 0; m_ovf = 0;
    end else begin
      case (m_phase)
        0: if (q.size() > 0) begin m_phase = 1; m_idx = 0; end
        1: if (host_ack) m_phase = 2;
        default: if (!host_ack) begin
          if (m_idx < 7) begin m_idx++; m_phase = 1; end
          else begin popd = 1; m_idx = 0; m_phase = 0; end
        end
      endcase
      if (popd) void'(q.pop_front());
      if (pcpi_ready && pcpi_wr) begin
        if (q.size() < DEPTH) q.push_back(pcpi_rd);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic       ev;
      logic [3:0] en;
      ev = (m_phase == 1);
      en = ev ? 4'((q[0] >> (4 * m_idx)) & 32'hF) : 4'h0;
      check("mdl_valid", 32'(nib_valid), 32'(ev));
      check("mdl_nib", 32'(nib_out), 32'(en));
      check("mdl_count", 32'(fifo_count), q.size());
      check("mdl_ovf", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (nib_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL wait_valid: nib_valid 0 after 100 cycles, required 1");
    end
  endtask

  // One full four-phase handshake; optionally push w on the release edge.
  task automatic ack_nib(input bit do_push, input logic [31:0] w, output logic [3:0] n);
    wait_valid();
    n = nib_out;
    host_ack = 1;
    @(negedge clk);
    host_ack = 0;
    if (do_push) begin pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = w; end
    @(negedge clk);
    pcpi_ready = 0; pcpi_wr = 0;
  endtask

  task automatic recv_word(output logic [31:0] w);
    logic [3:0] n;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      ack_nib(0, '0, n);
      w[i*4 +: 4] = n;
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = w;
    @(negedge clk);
    pcpi_ready = 0; pcpi_wr = 0;
  endtask

  logic [3:0] exp31 [8] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
  logic [3:0] exp36 [3] = '{4'h8, 4'h7, 4'h6};

  initial begin
    logic [31:0] w;
    logic [3:0]  n;
    // Reset state
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_valid", 32'(nib_valid), 0);
    check("rst_nib", 32'(nib_out), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst_n = 1;
    @(negedge clk);

    // ready without wr is ignored
    pcpi_ready = 1; pcpi_wr = 0; pcpi_rd = 32'hDEADBEEF;
    @(negedge clk);
    pcpi_ready = 0;
    @(negedge clk);
    check("nowr_count", 32'(fifo_count), 0);
    check("nowr_valid", 32'(nib_valid), 0);

    // Latency, stall hold, nibble order
    push_word(32'h89ABCDEF);
    check("lat_count_e0", 32'(fifo_count), 1);
    check("lat_valid_e0", 32'(nib_valid), 0);
    @(negedge clk);
    check("lat_valid_e1", 32'(nib_valid), 1);
    check("lat_nib_e1", 32'(nib_out), 32'hF);
    repeat (20) @(negedge clk);
    check("hold_valid", 32'(nib_valid), 1);
    check("hold_nib", 32'(nib_out), 32'hF);
    for (int i = 0; i < 8; i++) begin
      ack_nib(0, '0, n);
      check($sformatf("order_nib%0d", i), 32'(n), 32'(exp31[i]));
      if (i == 6) check("order_count_mid", 32'(fifo_count), 1);
    end
    check("order_count_end", 32'(fifo_count), 0);

    // Overflow on a full buffer
    pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = 32'h11111111;
    @(negedge clk); pcpi_rd = 32'h22222222;
    @(negedge clk); pcpi_rd = 32'h33333333;
    @(negedge clk); pcpi_ready = 0; pcpi_wr = 0;
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count", 32'(fifo_count), 2);
    recv_word(w); check("ovf_word0", w, 32'h11111111);
    recv_word(w); check("ovf_word1", w, 32'h22222222);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_drain_count", 32'(fifo_count), 0);
    rst_n = 0; @(negedge clk); rst_n = 1;
    check("ovf_cleared", 32'(overflow), 0);

    // Push on the same edge as the final pop of a full buffer
    push_word(32'h11111111);
    push_word(32'h22222222);
    check("fullpop_pre", 32'(fifo_count), 2);
    for (int i = 0; i < 7; i++) ack_nib(0, '0, n);
    ack_nib(1, 32'h33333333, n);
    check("fullpop_lastnib", 32'(n), 32'h1);
    check("fullpop_count", 32'(fifo_count), 2);
    check("fullpop_ovf", 32'(overflow), 0);
    recv_word(w); check("fullpop_word1", w, 32'h22222222);
    recv_word(w); check("fullpop_word2", w, 32'h33333333);

    // Reset mid-transfer, with a coincident push
    push_word(32'h12345678);
    for (int i = 0; i < 3; i++) begin
      ack_nib(0, '0, n);
      check($sformatf("midrst_nib%0d", i), 32'(n), 32'(exp36[i]));
    end
    wait_valid();
    check("midrst_nib3", 32'(nib_out), 32'h5);
    rst_n = 0; pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = 32'hCAFEF00D;
    @(negedge clk);
    rst_n = 1; pcpi_ready = 0; pcpi_wr = 0;
    check("midrst_valid", 32'(nib_valid), 0);
    check("midrst_count", 32'(fifo_count), 0);
    @(negedge clk);
    check("midrst_count2", 32'(fifo_count), 0);
    push_word(32'h0000000A);
    recv_word(w);
    check("midrst_first_nib", 32'(w[3:0]), 32'hA);
    check("midrst_word", w, 32'h0000000A);
    repeat (3) @(negedge clk);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
